// File: rtl/usb_token_rx.sv
// usb_token_rx: serial USB token packet decoder.
// Assembles the PID byte and the 16-bit token body from the unstuffed
// receive bit stream, checks the PID complement and the CRC5, and presents
// registered token fields qualified by a one-cycle tok_valid pulse.
// Optional feature macro: USB_ADDR_FILTER_EN (drop OUT/IN/SETUP tokens
// whose address differs from dev_addr; SOF always passes).
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for rx_sop
// PID       | shifting in the 8 PID bits, LSB first
// BODY      | shifting in 11 field bits + 5 CRC bits, CRC5 running
// WAIT_EOP  | all 16 body bits seen, rx_eop resolves the token
// DROP      | packet rejected or not a token, ignore bits until rx_eop

module usb_token_rx (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        rx_sop,
    input  logic        rx_bit,
    input  logic        rx_bit_valid,
    input  logic        rx_eop,
    input  logic [6:0]  dev_addr,
    output logic        tok_valid,
    output logic [3:0]  tok_pid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic [10:0] tok_frame,
    output logic        tok_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PID      = 3'd1;
    localparam logic [2:0] S_BODY     = 3'd2;
    localparam logic [2:0] S_WAIT_EOP = 3'd3;
    localparam logic [2:0] S_DROP     = 3'd4;

    localparam logic [4:0] CRC_INIT     = 5'b11111;
    localparam logic [4:0] CRC_POLY     = 5'b00101;
    localparam logic [4:0] CRC_RESIDUAL = 5'b01100;

    localparam logic [1:0] ERR_PID = 2'd0;
    localparam logic [1:0] ERR_CRC = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  pid_q, pid_d;
    logic [10:0] field_q, field_d;
    logic [4:0]  crc_q, crc_d;

    logic        tok_valid_q, tok_valid_d;
    logic        tok_err_q, tok_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [3:0]  tok_pid_q, tok_pid_d;
    logic [6:0]  tok_addr_q, tok_addr_d;
    logic [3:0]  tok_endp_q, tok_endp_d;
    logic [10:0] tok_frame_q, tok_frame_d;
    logic        busy_q, busy_d;

    logic [7:0]  pid_next;
    logic [4:0]  crc_next;
    logic        addr_match;

    assign pid_next = {rx_bit, pid_q[7:1]};
    assign crc_next = {crc_q[3:0], 1'b0} ^ ((crc_q[4] ^ rx_bit) ? CRC_POLY : 5'b00000);

`ifdef USB_ADDR_FILTER_EN
    // SOF carries a frame number, not an address, so it is never filtered
    assign addr_match = (pid_q[3:0] == 4'h5) || (field_q[6:0] == dev_addr);
`else
    logic unused_dev_addr;
    assign unused_dev_addr = ^dev_addr;
    assign addr_match      = 1'b1;
`endif

    // Next-state, field assembly and output pulse generation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pid_d       = pid_q;
        field_d     = field_q;
        crc_d       = crc_q;
        tok_valid_d = 1'b0;
        tok_err_d   = 1'b0;
        err_code_d  = err_code_q;
        tok_pid_d   = tok_pid_q;
        tok_addr_d  = tok_addr_q;
        tok_endp_d  = tok_endp_q;
        tok_frame_d = tok_frame_q;

        if (rx_sop) begin
            // a new sync always wins, whatever was in flight is abandoned
            state_d = S_PID;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_PID: begin
                    if (rx_eop) begin
                        tok_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = S_IDLE;
                    end else if (rx_bit_valid) begin
                        pid_d = pid_next;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (pid_next[7:4] != ~pid_next[3:0]) begin
                                tok_err_d  = 1'b1;
                                err_code_d = ERR_PID;
                                state_d    = S_DROP;
                            end else if (pid_next[1:0] != 2'b01) begin
                                state_d = S_DROP;
                            end else begin
                                state_d = S_BODY;
                                crc_d   = CRC_INIT;
                                cnt_d   = 4'd0;
                            end
                        end
                    end
                end
                S_BODY: begin
                    if (rx_eop) begin
                        tok_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = S_IDLE;
                    end else if (rx_bit_valid) begin
                        crc_d = crc_next;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q < 4'd11) begin
                            field_d = {rx_bit, field_q[10:1]};
                        end
                        if (cnt_q == 4'd15) begin
                            state_d = S_WAIT_EOP;
                        end
                    end
                end
                S_WAIT_EOP: begin
                    if (rx_eop) begin
                        state_d = S_IDLE;
                        if (crc_q != CRC_RESIDUAL) begin
                            tok_err_d  = 1'b1;
                            err_code_d = ERR_CRC;
                        end else if (addr_match) begin
                            tok_valid_d = 1'b1;
                            tok_pid_d   = pid_q[3:0];
                            tok_addr_d  = field_q[6:0];
                            tok_endp_d  = field_q[10:7];
                            tok_frame_d = field_q;
                        end
                    end else if (rx_bit_valid) begin
                        tok_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = S_DROP;
                    end
                end
                S_DROP: begin
                    if (rx_eop) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            pid_q       <= 8'd0;
            field_q     <= 11'd0;
            crc_q       <= CRC_INIT;
            tok_valid_q <= 1'b0;
            tok_err_q   <= 1'b0;
            err_code_q  <= 2'd0;
            tok_pid_q   <= 4'd0;
            tok_addr_q  <= 7'd0;
            tok_endp_q  <= 4'd0;
            tok_frame_q <= 11'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pid_q       <= pid_d;
            field_q     <= field_d;
            crc_q       <= crc_d;
            tok_valid_q <= tok_valid_d;
            tok_err_q   <= tok_err_d;
            err_code_q  <= err_code_d;
            tok_pid_q   <= tok_pid_d;
            tok_addr_q  <= tok_addr_d;
            tok_endp_q  <= tok_endp_d;
            tok_frame_q <= tok_frame_d;
            busy_q      <= busy_d;
        end
    end

    assign tok_valid = tok_valid_q;
    assign tok_err   = tok_err_q;
    assign err_code  = err_code_q;
    assign tok_pid   = tok_pid_q;
    assign tok_addr  = tok_addr_q;
    assign tok_endp  = tok_endp_q;
    assign tok_frame = tok_frame_q;
    assign busy      = busy_q;

endmodule

// File: doc/usb_token_rx.md
# usb_token_rx

Receive-side token packet decoder for the USB device core. Consumes the NRZI-decoded, bit-unstuffed serial stream from the receive front end, captures PID, address, endpoint or frame fields, and checks CRC5 serially over the 16 body bits. It presents one-cycle-qualified token fields to the protocol controller. It is the serial-assembly stage that sits directly upstream of the parallel token consumers.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all logic on rising edge
- n_rst  in  1  asynchronous, active-low reset
- rx_sop  in  1  one-cycle pulse: sync field done, first PID bit follows
- rx_bit  in  1  decoded data bit, wire order (LSB first); valid only with rx_bit_valid
- rx_bit_valid  in  1  one-cycle strobe per received bit; may assert every cycle
- rx_eop  in  1  one-cycle pulse at end of packet
- dev_addr  in  7  assigned device address; used only with USB_ADDR_FILTER_EN
- tok_valid  out  1  one-cycle pulse: good token received
- tok_pid  out  4  PID[3:0] of last good token
- tok_addr  out  7  address of last good token
- tok_endp  out  4  endpoint of last good token
- tok_frame  out  11  body bits b10..b0 of last good token (frame number for SOF)
- tok_err  out  1  one-cycle pulse: token rejected
- err_code  out  2  valid with tok_err: 0 PID check, 1 CRC, 2 length
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, PID, BODY, WAIT_EOP, DROP.
- IDLE: rx_sop -> PID, bit counter = 0.
- PID: shift in 8 bits LSB first. After the 8th bit:
  - pid[7:4] != ~pid[3:0] -> tok_err, err_code 0, then DROP.
  - pid[1:0] != 2'b01 (data or handshake) -> DROP silently.
  - otherwise (OUT 1, IN 9, SOF 5, SETUP D) -> BODY, crc = 5'b11111, counter = 0.
- BODY: 16 bits. Bits b0..b10 are the field and b11..b15 are the CRC. Every bit updates crc: fb = crc[4]^bit; crc = {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b0). After the 16th bit -> WAIT_EOP.
- Field mapping: addr = b6..b0, endp = b10..b7, frame = b10..b0.
- WAIT_EOP:
  - rx_eop with crc == 5'b01100 -> tok_valid, outputs updated, then IDLE.
  - rx_eop with any other residual -> tok_err, err_code 1, then IDLE.
  - rx_bit_valid before rx_eop -> tok_err, err_code 2, then DROP.
- rx_eop in PID or BODY -> tok_err, err_code 2, then IDLE.
- DROP: ignore bits; rx_eop -> IDLE.
- rx_sop in any non-IDLE state aborts the packet silently and restarts in PID.
- rx_eop and rx_bit_valid in the same cycle: the bit is ignored and the EOP is processed.
- tok_pid, tok_addr, tok_endp and tok_frame change only on tok_valid and hold until the next good token.
- tok_valid and tok_err are never high together.

## Timing
- Reset values: tok_valid = 0, tok_err = 0, err_code = 0, tok_pid = 0, tok_addr = 0, tok_endp = 0, tok_frame = 0, busy = 0, state = IDLE, crc = 5'b11111.
- All outputs are registered.
- tok_valid or tok_err rises one cycle after the rx_eop edge that resolves the packet.
- PID-check and length errors raised on a bit rise one cycle after that bit's rx_bit_valid.
- Back-to-back packets: rx_sop may arrive the cycle after rx_eop.
- No backpressure; the consumer must sample fields on tok_valid.
- Reset mid-packet returns immediately to IDLE with reset values and no pulse.

## Configuration
- USB_ADDR_FILTER_EN defined:
  - A CRC-good OUT, IN or SETUP token with addr != dev_addr is discarded: no tok_valid, no tok_err, outputs unchanged.
  - SOF is never filtered.
- Undefined: dev_addr is ignored and every CRC-good token pulses tok_valid.

## Test plan
- SETUP: PID bits 1,0,1,1,0,1,0,0; body addr 0x15, endp 0xE; CRC bits 1,0,1,1,1; then rx_eop -> tok_valid for 1 cycle, tok_pid=4'hD, tok_addr=7'h15, tok_endp=4'hE, tok_err=0.
- IN (0x69): addr 0x3A, endp 0xA, CRC bits 1,1,1,0,0 -> tok_valid, tok_pid=4'h9, tok_addr=7'h3A, tok_endp=4'hA.
- First scenario with body bit b3 inverted -> tok_err, err_code=1, no tok_valid, fields retain previous values.
- PID byte 0x2E -> tok_err, err_code=0, later bits ignored, IDLE after rx_eop.
- Two length cases:
  - rx_eop after 10 body bits -> tok_err, err_code=2.
  - DATA0 (0xC3) packet of any length -> no pulses, busy=1 until rx_eop.
- With USB_ADDR_FILTER_EN and dev_addr=7'h15:
  - IN token to 0x3A -> no pulses.
  - SOF with frame 11'h2A5 -> tok_valid, tok_frame=11'h2A5.
  - n_rst asserted mid-BODY -> all outputs 0, busy=0.
